// File: rtl/rounding_pkg.sv
// Shared defaults, the requester-id width helper and the default-width result
// record for the rounding arbiter.
package rounding_pkg;

    localparam int DEF_EXPONENT_WIDTH = 8;
    localparam int DEF_MANTISSA_WIDTH = 23;
    localparam int DEF_ROUNDING_BITS  = 3;
    localparam int DEF_NUM_REQ        = 4;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

    typedef struct packed {
        logic [DEF_EXPONENT_WIDTH-1:0] exponent;
        logic [DEF_MANTISSA_WIDTH-1:0] mantissa;
        logic                          overflow;
        logic [DEF_ID_WIDTH-1:0]       id;
    } result_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin grant picker: one-hot grant to the first requesting index at or
// after ptr, wrapping from the top index back to 0. Purely combinational.
module rr_picker
    import rounding_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int PTR_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant
);

    // Scan from ptr upward, skipping idle requesters, and grant the first hit.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rounding_arbiter.sv
// Round-robin arbiter in front of a single round-to-nearest-even stage.
// The winning requester's exponent/mantissa/guard bits are rounded and held
// in a one-deep output register with a valid/ready handshake.
// Optional: define ROUNDING_ARBITER_STATS_EN to add saturating 16-bit
// round-up and overflow counters as extra outputs.
module rounding_arbiter
    import rounding_pkg::*;
#(
    parameter int EXPONENT_WIDTH = DEF_EXPONENT_WIDTH,
    parameter int MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
    parameter int ROUNDING_BITS  = DEF_ROUNDING_BITS,
    parameter int NUM_REQ        = DEF_NUM_REQ
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*EXPONENT_WIDTH-1:0]   req_exponent,
    input  logic [NUM_REQ*MANTISSA_WIDTH-1:0]   req_mantissa,
    input  logic [NUM_REQ*ROUNDING_BITS-1:0]    req_rounding_bits,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [id_width(NUM_REQ)-1:0]        out_id,
    output logic [EXPONENT_WIDTH-1:0]           out_exponent,
    output logic [MANTISSA_WIDTH-1:0]           out_mantissa,
    output logic                                out_overflow
`ifdef ROUNDING_ARBITER_STATS_EN
    ,
    output logic [15:0]                         stat_roundup_count,
    output logic [15:0]                         stat_overflow_count
`endif
);

    localparam int IDW = id_width(NUM_REQ);

    typedef struct packed {
        logic [EXPONENT_WIDTH-1:0] exponent;
        logic [MANTISSA_WIDTH-1:0] mantissa;
        logic                      overflow;
        logic [IDW-1:0]            id;
    } res_t;

    logic [IDW-1:0]            ptr;
    logic [NUM_REQ-1:0]        grant;
    logic                      can_accept;
    logic                      accept;
    logic [IDW-1:0]            sel_id;
    logic [EXPONENT_WIDTH-1:0] sel_exp;
    logic [MANTISSA_WIDTH-1:0] sel_mant;
    logic [ROUNDING_BITS-1:0]  sel_rb;
    logic                      halfway;
    logic                      round_up;
    logic                      carry;
    logic [MANTISSA_WIDTH-1:0] mant_rnd;
    logic [EXPONENT_WIDTH-1:0] exp_inc;
    res_t                      res_next;
    res_t                      res_q;

    rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (IDW)
    ) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Ready goes to the winner only when the output slot is free or draining;
    // held off entirely during reset.
    always_comb begin
        can_accept = !out_valid || out_ready;
        req_ready  = (rst_n && can_accept) ? grant : '0;
        accept     = |req_ready;
    end

    // Encode the one-hot grant and steer the winner's operands.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_id = IDW'(i);
        end
        sel_exp  = req_exponent[sel_id*EXPONENT_WIDTH +: EXPONENT_WIDTH];
        sel_mant = req_mantissa[sel_id*MANTISSA_WIDTH +: MANTISSA_WIDTH];
        sel_rb   = req_rounding_bits[sel_id*ROUNDING_BITS +: ROUNDING_BITS];
    end

    // Round to nearest, ties to even; a mantissa carry-out bumps the exponent,
    // and reaching the all-ones exponent is reported as overflow.
    always_comb begin
        halfway  = (sel_rb == {1'b1, {(ROUNDING_BITS-1){1'b0}}});
        round_up = halfway ? sel_mant[0] : sel_rb[ROUNDING_BITS-1];
        {carry, mant_rnd} = {1'b0, sel_mant} + (MANTISSA_WIDTH+1)'(round_up);
        exp_inc  = sel_exp + EXPONENT_WIDTH'(1);
        res_next.exponent = sel_exp;
        res_next.mantissa = mant_rnd;
        res_next.overflow = 1'b0;
        res_next.id       = sel_id;
        if (carry) begin
            res_next.exponent = exp_inc;
            if (&exp_inc) begin
                res_next.mantissa = '0;
                res_next.overflow = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_q     <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            res_q     <= res_next;
            ptr       <= (sel_id == IDW'(NUM_REQ-1)) ? '0 : sel_id + IDW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_id       = res_q.id;
    assign out_exponent = res_q.exponent;
    assign out_mantissa = res_q.mantissa;
    assign out_overflow = res_q.overflow;

`ifdef ROUNDING_ARBITER_STATS_EN
    // Saturating event counters, stepped on accepts only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_roundup_count  <= '0;
            stat_overflow_count <= '0;
        end else if (accept) begin
            if (round_up && stat_roundup_count != 16'hFFFF)
                stat_roundup_count <= stat_roundup_count + 16'd1;
            if (res_next.overflow && stat_overflow_count != 16'hFFFF)
                stat_overflow_count <= stat_overflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rounding_arbiter.sv
// Directed bench for rounding_arbiter: reset state, round-robin order,
// rounding corner cases, backpressure, mid-operation reset and, when
// ROUNDING_ARBITER_STATS_EN is defined, counter saturation.
module tb_rounding_arbiter;
    import rounding_pkg::*;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam int RB = 3;
    localparam int N  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [EW-1:0]    exp_a  [N];
    logic [MW-1:0]    mant_a [N];
    logic [RB-1:0]    rb_a   [N];
    logic [N*EW-1:0]  req_exponent;
    logic [N*MW-1:0]  req_mantissa;
    logic [N*RB-1:0]  req_rounding_bits;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_id;
    logic [EW-1:0]    out_exponent;
    logic [MW-1:0]    out_mantissa;
    logic             out_overflow;
`ifdef ROUNDING_ARBITER_STATS_EN
    logic [15:0]      stat_roundup_count;
    logic [15:0]      stat_overflow_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_exponent[i*EW +: EW]      = exp_a[i];
            req_mantissa[i*MW +: MW]      = mant_a[i];
            req_rounding_bits[i*RB +: RB] = rb_a[i];
        end
    end

    rounding_arbiter #(
        .EXPONENT_WIDTH (EW),
        .MANTISSA_WIDTH (MW),
        .ROUNDING_BITS  (RB),
        .NUM_REQ        (N)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_exponent      (req_exponent),
        .req_mantissa      (req_mantissa),
        .req_rounding_bits (req_rounding_bits),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_id            (out_id),
        .out_exponent      (out_exponent),
        .out_mantissa      (out_mantissa),
        .out_overflow      (out_overflow)
`ifdef ROUNDING_ARBITER_STATS_EN
        ,
        .stat_roundup_count  (stat_roundup_count),
        .stat_overflow_count (stat_overflow_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accept from requester 0; valid is dropped right after the edge.
    task automatic do_one(input logic [EW-1:0] e, input logic [MW-1:0] m, input logic [RB-1:0] r);
        exp_a[0]  = e;
        mant_a[0] = m;
        rb_a[0]   = r;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
    endtask

    initial begin
        int exp_ids [5];
        exp_ids = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            exp_a[i]  = EW'(8'h10 + i);
            mant_a[i] = MW'(23'h11 + 23'h100 * i);
            rb_a[i]   = '0;
        end

        // reset state, with requests pending
        #23;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_exponent", out_exponent, 0);
        chk("rst_out_mantissa", out_mantissa, 0);
        chk("rst_out_overflow", out_overflow, 0);
        chk("rst_req_ready", req_ready, 4'b0000);
        rst_n = 1'b1;
        #1;

        // round-robin with all requesters valid and the sink always ready
        out_ready = 1'b1;
        chk("rr_first_ready", req_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_out_valid", out_valid, 1);
            chk("rr_out_id", out_id, exp_ids[k]);
            chk("rr_out_exponent", out_exponent, 8'h10 + exp_ids[k]);
            chk("rr_out_mantissa", out_mantissa, 23'h11 + 23'h100 * exp_ids[k]);
            chk("rr_next_ready", req_ready, 4'b0001 << ((exp_ids[k] + 1) % 4));
        end
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", req_ready, 4'b0000);
        tick();
        chk("drain_out_valid", out_valid, 0);

        // rounding corner cases, back to back
        do_one(8'h10, 23'h000001, 3'b100);
        chk("tie_odd_mant", out_mantissa, 23'h000002);
        chk("tie_odd_exp", out_exponent, 8'h10);
        chk("tie_odd_id", out_id, 0);
        do_one(8'h10, 23'h000002, 3'b100);
        chk("tie_even_mant", out_mantissa, 23'h000002);
        do_one(8'h20, 23'h000005, 3'b011);
        chk("below_half_mant", out_mantissa, 23'h000005);
        do_one(8'h20, 23'h000004, 3'b101);
        chk("above_half_mant", out_mantissa, 23'h000005);
        do_one(8'hFD, 23'h7FFFFF, 3'b110);
        chk("carry_exp", out_exponent, 8'hFE);
        chk("carry_mant", out_mantissa, 0);
        chk("carry_ovf", out_overflow, 0);
        do_one(8'hFE, 23'h7FFFFF, 3'b110);
        chk("ovf_exp", out_exponent, 8'hFF);
        chk("ovf_mant", out_mantissa, 0);
        chk("ovf_flag", out_overflow, 1);
        chk("ovf_valid", out_valid, 1);

        // backpressure: result held, no grants while the slot is full
        out_ready = 1'b0;
        exp_a[2]  = 8'h33;
        mant_a[2] = 23'h000123;
        rb_a[2]   = 3'b000;
        req_valid = 4'b0100;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready", req_ready, 4'b0000);
            chk("bp_valid", out_valid, 1);
            chk("bp_exponent", out_exponent, 8'hFF);
            chk("bp_overflow", out_overflow, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 4'b0100);
        tick();
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_swap_id", out_id, 2);
        chk("bp_swap_exponent", out_exponent, 8'h33);
        chk("bp_swap_mantissa", out_mantissa, 23'h000123);
        chk("bp_swap_overflow", out_overflow, 0);

        // pointer now 3 and a result is held; reset mid-operation
        req_valid = 4'b0000;
        out_ready = 1'b0;
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_id", out_id, 0);
        chk("mid_rst_exponent", out_exponent, 0);
        chk("mid_rst_ready", req_ready, 4'b0000);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", req_ready, 4'b0010);
        tick();
        chk("post_rst_id", out_id, 1);
        chk("post_rst_valid", out_valid, 1);
        req_valid = 4'b0000;
        tick();

`ifdef ROUNDING_ARBITER_STATS_EN
        chk("stat_roundup_start", stat_roundup_count, 0);
        chk("stat_overflow_start", stat_overflow_count, 0);
        exp_a[0]  = 8'h40;
        mant_a[0] = 23'h000000;
        rb_a[0]   = 3'b111;
        req_valid = 4'b0001;
        repeat (70000) tick();
        req_valid = 4'b0000;
        tick();
        chk("stat_roundup_sat", stat_roundup_count, 16'hFFFF);
        chk("stat_overflow_none", stat_overflow_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
